// File: rtl/jump_commit.sv
// Jump commit stage: evaluates opcode-39 conditions, commits next PC / rJ / overflow clear, then pulses done.
// Optional JUMP_STATS_EN adds a saturating taken-jump counter with synchronous clear.
module jump_commit #(
  parameter int ADDR_W   = 12,
  parameter int MEM_SIZE = 4000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [5:0]        opcode,
  input  logic [3:0]        field,
  input  logic [ADDR_W-1:0] m,
  input  logic [ADDR_W-1:0] pc,
  input  logic              reg_cond,
  input  logic              ovf,
  input  logic [1:0]        cmp,
`ifdef JUMP_STATS_EN
  input  logic              stats_clr,
  output logic [15:0]       taken_cnt,
`endif
  output logic              busy,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_next,
  output logic              j_load,
  output logic [ADDR_W-1:0] j_value,
  output logic              ovf_clr,
  output logic              taken,
  output logic              done,
  output logic              illegal
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MEM_SIZE - 1);

  typedef enum logic [1:0] {S_IDLE, S_LATCH, S_COMMIT, S_DONE} state_t;
  state_t state, state_nx;

  logic [5:0]        c_op;
  logic [3:0]        c_field;
  logic [ADDR_W-1:0] c_m, c_pc;
  logic              c_cond, c_ovf;
  logic [1:0]        c_cmp;

  logic take, jsj, ill, oclr;
  logic take_r, jsj_r, ill_r, oclr_r;
  logic less, greater, equal;
  logic [ADDR_W-1:0] inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = (state != S_IDLE);
    pc_load  = 1'b0;
    j_load   = 1'b0;
    ovf_clr  = 1'b0;
    done     = 1'b0;
    illegal  = 1'b0;
    case (state)
      S_IDLE:   if (start) state_nx = S_LATCH;
      S_LATCH:  state_nx = S_COMMIT;
      S_COMMIT: begin
        state_nx = S_DONE;
        pc_load  = 1'b1;
        j_load   = take_r & ~jsj_r;
        ovf_clr  = oclr_r;
      end
      default: begin
        state_nx = S_IDLE;
        done     = 1'b1;
        illegal  = ill_r;
      end
    endcase
  end

  // Inputs are only trusted in the capture cycle; everything downstream uses the copies.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_op <= '0; c_field <= '0; c_m <= '0; c_pc <= '0;
      c_cond <= 1'b0; c_ovf <= 1'b0; c_cmp <= '0;
    end else if (state == S_IDLE && start) begin
      c_op <= opcode; c_field <= field; c_m <= m; c_pc <= pc;
      c_cond <= reg_cond; c_ovf <= ovf; c_cmp <= cmp;
    end
  end

  // cmp=11 falls through to EQUAL.
  assign less    = (c_cmp == 2'b01);
  assign greater = (c_cmp == 2'b10);
  assign equal   = ~less & ~greater;
  assign inc     = (c_pc >= LAST) ? '0 : c_pc + ADDR_W'(1);

  always_comb begin
    take = 1'b0;
    jsj  = 1'b0;
    ill  = 1'b0;
    oclr = 1'b0;
    if (c_op == 6'd39) begin
      case (c_field)
        4'd0: take = 1'b1;
        4'd1: begin take = 1'b1; jsj = 1'b1; end
        4'd2: begin take = c_ovf;  oclr = 1'b1; end
        4'd3: begin take = ~c_ovf; oclr = 1'b1; end
        4'd4: take = less;
        4'd5: take = equal;
        4'd6: take = greater;
        4'd7: take = ~less;
        4'd8: take = ~equal;
        4'd9: take = ~greater;
        default: ill = 1'b1;
      endcase
    end else if (c_op >= 6'd40 && c_op <= 6'd47) begin
      if (c_field <= 4'd7) take = c_cond;
      else                 ill  = 1'b1;
    end else begin
      ill = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      take_r <= 1'b0; jsj_r <= 1'b0; ill_r <= 1'b0; oclr_r <= 1'b0;
      pc_next <= '0; j_value <= '0; taken <= 1'b0;
    end else if (state == S_LATCH) begin
      take_r  <= take;
      jsj_r   <= jsj;
      ill_r   <= ill;
      oclr_r  <= oclr;
      pc_next <= take ? c_m : inc;
      j_value <= inc;
    end else if (state == S_COMMIT) begin
      taken <= take_r;
    end
  end

`ifdef JUMP_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                               taken_cnt <= '0;
    else if (stats_clr)                                    taken_cnt <= '0;
    else if (state == S_COMMIT && take_r && taken_cnt != 16'hFFFF) taken_cnt <= taken_cnt + 16'd1;
  end
`endif

endmodule
